// File: rtl/lsu_mem_master.sv
// ============================================================================
// Module   : lsu_mem_master
// Purpose  : Byte-addressed load/store initiator for a word-addressed RAM.
//            Optional macro MISALIGN_TRAP_EN makes misaligned half/word
//            requests return an error instead of being silently aligned.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int LAT_W = (MEM_RD_LAT > 0) ? $clog2(MEM_RD_LAT + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [2:0]            r_state;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic [DATA_WIDTH-1:0] w_idx;
    logic                  w_idx_bad;
    logic                  w_size_bad;
    logic                  w_misalign;
    logic [1:0]            w_off;
    logic                  w_acc_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_val;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_rd_done;

    // ------------------------------------------------------------------
    // Accept-time decode: word index, error detection, effective lane
    // ------------------------------------------------------------------
    assign w_idx      = {2'b00, req_addr[DATA_WIDTH-1:2]};
    assign w_idx_bad  = (w_idx >= DATA_WIDTH'(MEM_WORDS));
    assign w_size_bad = (req_size == SZ_RSVD);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_off      = req_addr[1:0];
`else
    assign w_misalign = 1'b0;
    // Offending low address bits are dropped so the access stays aligned.
    always_comb begin
        case (req_size)
            SZ_HALF: w_off = {req_addr[1], 1'b0};
            SZ_WORD: w_off = 2'b00;
            default: w_off = req_addr[1:0];
        endcase
    end
`endif

    assign w_acc_err = w_idx_bad | w_size_bad | w_misalign;

    // ------------------------------------------------------------------
    // Little-endian lane extraction and extension for loads
    // ------------------------------------------------------------------
    assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        case (r_size)
            SZ_BYTE: w_load_val = {{(DATA_WIDTH-8){~r_uns & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_val = {{(DATA_WIDTH-16){~r_uns & w_half[15]}}, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    // Read-modify-write: only the addressed lane takes the store data.
    always_comb begin
        w_merged = mem_rdata;
        case (r_size)
            SZ_BYTE: w_merged[{r_off, 3'b000} +: 8]     = r_wdata[7:0];
            SZ_HALF: w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    // Read data is sampled on the edge closing the last mem_re cycle.
    always_comb begin
        if (MEM_RD_LAT == 0) begin
            w_rd_done = (r_state == S_RD);
        end else begin
            w_rd_done = (r_state == S_WAIT) && (r_lat_cnt == LAT_W'(MEM_RD_LAT));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_idx       <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_lat_cnt <= '0;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_off   <= w_off;
                        r_wdata <= req_wdata;
                        r_idx   <= w_idx;
                        r_err   <= w_acc_err;
                        if (w_acc_err) begin
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            r_mem_wdata <= req_wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD, S_WAIT: begin
                    if (w_rd_done) begin
                        if (r_we) begin
                            r_mem_wdata <= w_merged;
                            r_state     <= S_WR;
                        end else begin
                            r_rdata <= w_load_val;
                            r_state <= S_RESP;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                        r_state   <= S_WAIT;
                    end
                end
                S_WR: begin
                    r_rdata <= '0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state so an async reset kills them.
    assign req_ready = (r_state == S_IDLE);
    assign mem_re    = (r_state == S_RD) || (r_state == S_WAIT);
    assign mem_we    = (r_state == S_WR);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_err   = (r_state == S_RESP) && r_err;
    assign rsp_rdata = r_rdata;
    assign mem_addr  = r_idx;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// ============================================================================
// Module   : tb_lsu_mem_master
// Purpose  : Self-checking bench for lsu_mem_master against a byte-array
//            reference memory. Honours MISALIGN_TRAP_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_mem_master;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    logic [31:0] tb_ram     [0:63];
    logic [31:0] init_words [0:63];
    logic [7:0]  ref_bytes  [0:255];
    logic        load_ram;

    int n_tests = 0;
    int n_fail  = 0;
    int we_total = 0, re_total = 0, both_total = 0, rsp_total = 0;
    logic [31:0] last_acc_addr = '0;

    lsu_mem_master #(
        .DATA_WIDTH (32),
        .MEM_WORDS  (64),
        .MEM_RD_LAT (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < 64; i++) tb_ram[i] <= init_words[i];
        end else begin
            if (mem_we && mem_addr < 64) tb_ram[mem_addr[5:0]] <= mem_wdata;
            if (mem_re && mem_addr < 64) mem_rdata <= tb_ram[mem_addr[5:0]];
        end
    end

    always @(negedge clk) begin
        if (mem_we) we_total <= we_total + 1;
        if (mem_re) re_total <= re_total + 1;
        if (mem_we && mem_re) both_total <= both_total + 1;
        if (rsp_valid) rsp_total <= rsp_total + 1;
        if (mem_we || mem_re) last_acc_addr <= mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: drives the request, predicts everything from the
    // byte-array model, checks timing, strobes and data, then updates the model.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] got_rd, output logic got_err);
        logic [31:0] idx, a, exp_rd, mask;
        logic        err, got;
        int          nb, exp_lat, exp_we, exp_re, lat, we0, re0, both0;

        idx = addr >> 2;
        err = (idx >= 64) || (sz == 2'b11);
`ifdef MISALIGN_TRAP_EN
        if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) err = 1'b1;
`endif
        a = addr;
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
        nb = 1 << sz;

        exp_rd = '0;
        if (!err && !we) begin
            for (int k = 0; k < nb; k++) exp_rd |= 32'(ref_bytes[a[7:0] + 8'(k)]) << (8 * k);
            if (!uns && nb < 4 && exp_rd[8*nb-1]) begin
                mask = (32'h1 << (8 * nb)) - 32'h1;
                exp_rd |= ~mask;
            end
        end
        exp_lat = err ? 1 : (!we ? 2 + LAT : (sz == 2'b10 ? 2 : 3 + LAT));
        exp_we  = (we && !err) ? 1 : 0;
        exp_re  = (!err && (!we || sz != 2'b10)) ? 1 + LAT : 0;

        @(negedge clk);
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        we0 = we_total; re0 = re_total; both0 = both_total;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        lat = 1; got = 1'b0;
        while (!got && lat <= 12) begin
            if (rsp_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        check("rsp_seen", 32'(got), 32'd1);
        got_rd = rsp_rdata; got_err = rsp_err;
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("mem_we_pulses", 32'(we_total - we0), 32'(exp_we));
        check("mem_re_cycles", 32'(re_total - re0), 32'(exp_re));
        check("we_re_overlap", 32'(both_total - both0), 32'd0);
        if (exp_we + exp_re > 0) check("mem_addr", last_acc_addr, idx);

        @(posedge clk); #1;
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(req_ready), 32'd1);
        check("rdata_hold", rsp_rdata, exp_rd);

        if (!err && we)
            for (int k = 0; k < nb; k++) ref_bytes[a[7:0] + 8'(k)] = 8'(wd >> (8 * k));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          we_s, rsp_s;

        rst_n = 1'b0; load_ram = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            init_words[i] = $urandom;
            for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = 8'(init_words[i] >> (8 * k));
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        load_ram = 1'b0; rst_n = 1'b1;

        // Word store / load
        run_req(1, 2'b10, 0, 32'h28, 32'hDEADBEEF, rd, er);
        run_req(0, 2'b10, 0, 32'h28, 32'h0, rd, er);
        check("p1_word_load", rd, 32'hDEADBEEF);

        // Byte merge and byte loads
        run_req(1, 2'b10, 0, 32'h78, 32'hCAFEBABE, rd, er);
        run_req(1, 2'b00, 0, 32'h79, 32'h000000AB, rd, er);
        run_req(0, 2'b10, 0, 32'h78, 32'h0, rd, er);
        check("p2_merged_word", rd, 32'hCAFEABBE);
        run_req(0, 2'b00, 0, 32'h79, 32'h0, rd, er);
        check("p2_byte_signed", rd, 32'hFFFFFFAB);
        run_req(0, 2'b00, 1, 32'h79, 32'h0, rd, er);
        check("p2_byte_unsigned", rd, 32'h000000AB);

        // Half loads and store
        run_req(0, 2'b01, 0, 32'h7A, 32'h0, rd, er);
        check("p3_half_signed", rd, 32'hFFFFCAFE);
        run_req(0, 2'b01, 1, 32'h7A, 32'h0, rd, er);
        check("p3_half_unsigned", rd, 32'h0000CAFE);
        run_req(1, 2'b01, 0, 32'h78, 32'h00001234, rd, er);
        run_req(0, 2'b10, 0, 32'h78, 32'h0, rd, er);
        check("p3_half_merged", rd, 32'hCAFE1234);

        // Error cases
        run_req(0, 2'b10, 0, 32'h100, 32'h0, rd, er);
        check("p4_oob_err", 32'(er), 32'd1);
        run_req(0, 2'b11, 0, 32'h10, 32'h0, rd, er);
        check("p4_size_err", 32'(er), 32'd1);
        run_req(1, 2'b11, 0, 32'h14, 32'h12345678, rd, er);

        // Reset during the read phase of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h51; req_wdata = 32'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("p5_in_read_phase", 32'(mem_re), 32'd1);
        we_s = we_total; rsp_s = rsp_total;
        #2 rst_n = 1'b0;
        #1;
        check("p5_re_async_drop", 32'(mem_re), 32'd0);
        check("p5_we_async_drop", 32'(mem_we), 32'd0);
        check("p5_ready_in_rst", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("p5_no_write", 32'(we_total - we_s), 32'd0);
        check("p5_no_rsp", 32'(rsp_total - rsp_s), 32'd0);
        check("p5_ready_after", 32'(req_ready), 32'd1);
        run_req(0, 2'b10, 0, 32'h50, 32'h0, rd, er);

        // Misaligned half store
        run_req(1, 2'b10, 0, 32'h28, 32'h11223344, rd, er);
        run_req(1, 2'b01, 0, 32'h29, 32'h0000BEEF, rd, er);
`ifdef MISALIGN_TRAP_EN
        check("p6_misalign_err", 32'(er), 32'd1);
        run_req(0, 2'b10, 0, 32'h28, 32'h0, rd, er);
        check("p6_word_kept", rd, 32'h11223344);
`else
        check("p6_misalign_err", 32'(er), 32'd0);
        run_req(0, 2'b10, 0, 32'h28, 32'h0, rd, er);
        check("p6_low_half", rd, 32'h1122BEEF);
`endif

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            logic        r_we_s, r_uns_s;
            logic [1:0]  r_sz_s;
            logic [31:0] r_addr_s;
            int          pick;
            r_we_s  = 1'($urandom_range(0, 1));
            r_uns_s = 1'($urandom_range(0, 1));
            pick    = $urandom_range(0, 15);
            r_sz_s  = (pick == 0) ? 2'b11 : 2'(pick % 3);
            r_addr_s = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(256, 511))
                                                     : 32'($urandom_range(0, 255));
            run_req(r_we_s, r_sz_s, r_uns_s, r_addr_s, $urandom, rd, er);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
